// File: rtl/multiplicador_serie.sv
// Sequential unsigned shift-and-add multiplier: one operand bit per three cycles
// (evaluate, add one-or-zero, shift), Moore outputs decoded from the state register.
module multiplicador_serie #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inicio,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   producto,
   output logic                 listo,
   output logic                 ocupado
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      StReposo    = 3'b000,
      StEvaluar   = 3'b001,
      StSumarCero = 3'b010,
      StSumarUno  = 3'b011,
      StDesplazar = 3'b100,
      StFin       = 3'b101
   } estado_e;

   estado_e              estado_q, estado_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   producto_q, producto_d;

   logic [2*WIDTH:0]     desplazado;
   logic                 ultimo_bit;

   assign desplazado = {acc_q, mplier_q} >> 1;
   assign ultimo_bit = (cnt_q == CntW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q   <= StReposo;
         mcand_q    <= '0;
         acc_q      <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         producto_q <= '0;
      end else begin
         estado_q   <= estado_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         producto_q <= producto_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      producto_d = producto_q;

      unique case (estado_q)
         StReposo: begin
            if (inicio) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               estado_d = StEvaluar;
            end
         end
         StEvaluar: begin
            estado_d = mplier_q[0] ? StSumarUno : StSumarCero;
         end
         StSumarUno: begin
            // Carry out of the add lands in acc[WIDTH] and is shifted down next.
            acc_d    = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q};
            estado_d = StDesplazar;
         end
         StSumarCero: begin
            estado_d = StDesplazar;
         end
         StDesplazar: begin
            acc_d    = desplazado[2*WIDTH:WIDTH];
            mplier_d = desplazado[WIDTH-1:0];
            cnt_d    = cnt_q + CntW'(1);
            if (ultimo_bit) begin
               producto_d = desplazado[2*WIDTH-1:0];
               estado_d   = StFin;
            end else begin
               estado_d   = StEvaluar;
            end
         end
         StFin: begin
            estado_d = StReposo;
         end
         default: begin
            estado_d = StReposo;
         end
      endcase
   end

   assign producto = producto_q;
   assign listo    = (estado_q == StFin);
   assign ocupado  = (estado_q == StEvaluar)   || (estado_q == StSumarCero) ||
                     (estado_q == StSumarUno)  || (estado_q == StDesplazar);

endmodule

// File: tb/tb_multiplicador_serie.sv
// Directed bench for multiplicador_serie: WIDTH=8 and WIDTH=4 instances,
// hand-computed products, latency, handshake and reset-abort behaviour.
module tb_multiplicador_serie;

   logic        clk;
   logic        rst;
   logic        inicio;
   logic [7:0]  a, b;
   logic [15:0] producto;
   logic        listo, ocupado;

   logic        inicio4;
   logic [3:0]  a4, b4;
   logic [7:0]  producto4;
   logic        listo4, ocupado4;

   int checks   = 0;
   int failures = 0;

   multiplicador_serie #(.WIDTH(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .inicio   (inicio),
      .a        (a),
      .b        (b),
      .producto (producto),
      .listo    (listo),
      .ocupado  (ocupado)
   );

   multiplicador_serie #(.WIDTH(4)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .inicio   (inicio4),
      .a        (a4),
      .b        (b4),
      .producto (producto4),
      .listo    (listo4),
      .ocupado  (ocupado4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse inicio for one edge, then wait (bounded) for listo.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int occ);
      @(negedge clk);
      a      = av;
      b      = bv;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      a      = 8'h5A;
      b      = 8'hC3;
      lat    = 0;
      occ    = 0;
      while (!listo && lat < 200) begin
         if (ocupado) occ++;
         @(negedge clk);
         lat++;
      end
   endtask

   int          lat, occ, hits, first_hit, second_hit, n;
   logic        stable, listo_seen;
   logic [7:0]  av_tab [0:63];
   logic [7:0]  bv_tab [0:63];
   logic [15:0] pe_tab [0:63];

   initial begin
      rst     = 1'b0;
      inicio  = 1'b0;
      a       = '0;
      b       = '0;
      inicio4 = 1'b0;
      a4      = '0;
      b4      = '0;

      repeat (3) @(negedge clk);
      check("reset_producto", producto, 16'h0000);
      check("reset_listo",    listo,    1'b0);
      check("reset_ocupado",  ocupado,  1'b0);
      check("reset_producto4", producto4, 8'h00);
      rst = 1'b1;

      // 13 * 11 = 0x8F, latency 24, ocupado for 24 cycles
      run_op(8'd13, 8'd11, lat, occ);
      check("lat_13x11",   lat,      24);
      check("occ_13x11",   occ,      24);
      check("prod_13x11",  producto, 16'h008F);
      check("ocup_in_fin", ocupado,  1'b0);
      @(negedge clk);
      check("listo_one_cycle", listo, 1'b0);

      // Idle for 50 cycles: result held, no strobe
      stable     = 1'b1;
      listo_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (producto !== 16'h008F) stable = 1'b0;
         if (listo) listo_seen = 1'b1;
      end
      check("idle_hold_prod",  stable,     1'b1);
      check("idle_no_listo",   listo_seen, 1'b0);

      run_op(8'hFF, 8'hFF, lat, occ);
      check("prod_ffxff", producto, 16'hFE01);
      check("lat_ffxff",  lat,      24);
      run_op(8'h00, 8'hA5, lat, occ);
      check("prod_00xa5", producto, 16'h0000);
      run_op(8'h80, 8'h02, lat, occ);
      check("prod_80x02", producto, 16'h0100);
      @(negedge clk);

      // inicio held high, operands changing every cycle
      hits       = 0;
      first_hit  = -1;
      second_hit = -1;
      for (int i = 0; i < 62; i++) begin
         @(negedge clk);
         if (listo) begin
            hits++;
            if (hits == 1) first_hit = i;
            else if (hits == 2) second_hit = i;
            if (i >= 25) check("held_prod", producto, {16'h0, pe_tab[i-25]});
            else         check("held_early_listo", i, 25);
         end
         av_tab[i] = 8'(i * 37 + 5);
         bv_tab[i] = 8'(i * 11 + 200);
         pe_tab[i] = 16'(av_tab[i]) * 16'(bv_tab[i]);
         a      = av_tab[i];
         b      = bv_tab[i];
         inicio = 1'b1;
      end
      inicio = 1'b0;
      check("held_hits",   hits,       2);
      check("held_first",  first_hit,  25);
      check("held_second", second_hit, 51);
      n = 0;
      while ((ocupado || listo) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("held_drain", n < 100, 1'b1);

      // Reset at cycle 10 of an operation aborts it
      @(negedge clk);
      a      = 8'd7;
      b      = 8'd9;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_abort_ocup", ocupado, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("abort_producto", producto, 16'h0000);
      check("abort_listo",    listo,    1'b0);
      check("abort_ocupado",  ocupado,  1'b0);
      @(negedge clk);
      rst = 1'b1;
      run_op(8'd3, 8'd5, lat, occ);
      check("post_abort_prod", producto, 16'd15);
      check("post_abort_lat",  lat,      24);

      // WIDTH=4: 15 * 15 = 0xE1 after 12 edges
      @(negedge clk);
      a4      = 4'd15;
      b4      = 4'd15;
      inicio4 = 1'b1;
      @(negedge clk);
      inicio4 = 1'b0;
      lat     = 0;
      while (!listo4 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("w4_lat",  lat,       12);
      check("w4_prod", producto4, 8'hE1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multiplicador_serie.md
# multiplicador_serie

Sequential unsigned shift-and-add multiplier, the multiplication counterpart of the team's restoring divider. It uses the same control style: a Moore FSM with a per-bit evaluate / add-one-or-zero / shift loop. It takes two WIDTH-bit operands on a start pulse and produces a 2·WIDTH-bit product after a fixed latency. It sits beside the divider in the arithmetic unit and is driven by the same sequencer through an inicio/listo handshake.

## Interface
- WIDTH, 8: operand width in bits; minimum 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- inicio  input  1  start request; sampled only in REPOSO.
- a  input  WIDTH  multiplicand, unsigned; captured with inicio.
- b  input  WIDTH  multiplier, unsigned; captured with inicio.
- producto  output  2·WIDTH  result register; holds the last completed product.
- listo  output  1  one-cycle done strobe; high only in FIN.
- ocupado  output  1  high in EVALUAR, SUMAR_CERO, SUMAR_UNO and DESPLAZAR.

## Operation
- State encoding (3-bit): REPOSO 000, EVALUAR 001, SUMAR_CERO 010, SUMAR_UNO 011, DESPLAZAR 100, FIN 101. The unused codes 110 and 111 go to REPOSO on the next edge.
- Internal registers:
  - mcand: WIDTH bits.
  - acc: WIDTH+1 bits, upper half of the product plus carry.
  - mplier: WIDTH bits, lower half of the product.
  - cnt: ceil(log2 WIDTH) bits.
- REPOSO with inicio=1: mcand←a, mplier←b, acc←0, cnt←0; next state EVALUAR. With inicio=0, stay in REPOSO.
- EVALUAR: mplier[0]=1 goes to SUMAR_UNO, otherwise SUMAR_CERO. No datapath change.
- SUMAR_UNO: acc←acc[WIDTH-1:0]+mcand. The carry is kept in acc[WIDTH]. Next state DESPLAZAR.
- SUMAR_CERO: datapath unchanged; next state DESPLAZAR.
- DESPLAZAR:
  - {acc, mplier} ← {acc, mplier} >> 1, zero-filled at the MSB.
  - cnt←cnt+1.
  - If cnt was WIDTH-1 before the increment: producto←the shifted {acc[WIDTH-1:0], mplier} and next state FIN. Otherwise next state EVALUAR.
- FIN: listo=1; next state REPOSO unconditionally.
- Arithmetic rules:
  - All operations are unsigned.
  - The product never overflows 2·WIDTH bits.
  - acc[WIDTH] is always 0 after each shift.
- Outputs are decoded from the state register only (Moore). inicio, a and b have no combinational path to any output.
- Reset values: producto=0, listo=0, ocupado=0, state REPOSO, and acc, mplier, mcand, cnt all 0.

## Timing
- Let edge k be the edge that samples inicio=1 in REPOSO.
- Each operand bit takes exactly 3 cycles: EVALUAR, SUMAR_x, DESPLAZAR. Latency is independent of the data.
- State is FIN after edge k+3·WIDTH; for WIDTH=8 that is edge k+24. listo is high for exactly that one cycle.
- producto updates at edge k+3·WIDTH and is valid while listo is high. It holds until the next completion.
- ocupado rises after edge k and falls after edge k+3·WIDTH.
- inicio in any state other than REPOSO, including FIN, is ignored. There is no queuing. a and b may change freely after edge k.
- If inicio is held high continuously: REPOSO lasts one cycle after FIN, and the next operation is captured at edge k+3·WIDTH+2. The start-to-start period is 3·WIDTH+2 cycles.
- Reset asserted mid-operation aborts immediately (asynchronous). The operation in progress is discarded, producto clears to 0, and no listo is generated.
- After rst deasserts, the first edge can already capture inicio.

## Test plan
- WIDTH=8, a=13, b=11, inicio pulsed for one cycle → listo high exactly 24 edges later for one cycle, producto=0x008F, ocupado high for 24 cycles.
- a=0xFF, b=0xFF → producto=0xFE01. Then a=0x00, b=0xA5 → producto=0x0000. Then a=0x80, b=0x02 → producto=0x0100.
- inicio held high, operands changing every cycle → completions 26 cycles apart. Each producto matches the operands present at its capture edge; inicio pulses mid-operation leave the result unchanged.
- rst asserted at cycle 10 of an operation (a=7, b=9) → producto=0, listo=0, ocupado=0 immediately. A new start with a=3, b=5 gives producto=15 with nominal latency.
- After a result of 0x8F with inicio kept low for 50 cycles → producto stays 0x8F and listo stays 0.
- WIDTH=4 instance, a=15, b=15 → producto=0xE1 after 12 edges.
